route_player: RTL and testbench
===============================

ROUTE_PLAYER -- requirements
Module: route_player

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (input, 1, rising-edge clock); rst (input, 1, asynchronous active-high reset).
REQ-002 The block SHALL have these remaining ports:
- start  input  1  pulse; begins replay of the solved path.
- q_move  input  2  move word from the path queue, valid the cycle after q_dequeue.
- q_finish  input  1  queue exhausted.
- q_load  output  1  one-cycle pulse; snapshot stack into queue.
- q_rst_front  output  1  one-cycle pulse; rewind queue front.
- q_dequeue  output  1  one-cycle pulse; advance queue.
- x_out  output  4  current replay x.
- y_out  output  4  current replay y.
- step_valid  output  1  x_out/y_out hold a new step.
- step_ready  input  1  consumer accepts step.
- step_count  output  9  accepted steps, 0..256.
- busy  output  1  replay in progress.
- done  output  1  replay complete, held until next start.
- reached  output  1  done, and final position is (15,15).
- err  output  1  illegal move seen, held until next start.

Function
REQ-003 Move encoding SHALL be: 00 = y-1, 01 = x+1, 10 = x-1, 11 = y+1.
REQ-004 The FSM SHALL have states IDLE, LOAD, FETCH, WAIT, APPLY, EMIT, DONE, ERR.
REQ-005 IDLE: start=1 SHALL go to LOAD; other inputs are ignored.
REQ-006 LOAD SHALL assert q_load and q_rst_front for exactly one cycle, clear x/y to (0,0), clear step_count, clear done/reached/err, then go to FETCH.
REQ-007 FETCH: q_finish=1 SHALL go to DONE; otherwise it SHALL pulse q_dequeue for one cycle and go to WAIT.
REQ-008 WAIT SHALL register q_move and go to APPLY.
REQ-009 APPLY SHALL compute the next coordinate with 4-bit arithmetic.
- Legal move: update x/y, go to EMIT.
- Illegal move (see REQ-016): go to ERR.
REQ-010 EMIT SHALL hold step_valid=1 with stable x_out/y_out until step_ready=1.
- On acceptance, step_count SHALL increment and the FSM SHALL go to FETCH.
- Minimum 4 cycles per accepted step.
REQ-011 DONE SHALL assert done, and reached = (x_out==15 && y_out==15).
- DONE SHALL stay until start, which restarts via LOAD.
REQ-012 ERR SHALL assert err, freeze x/y and step_count, and stay until start.
REQ-013 busy SHALL equal 1 in LOAD, FETCH, WAIT, APPLY and EMIT.
REQ-014 start while busy SHALL be ignored.
REQ-015 step_count SHALL saturate at 256.
- A 257th step SHALL go to ERR.

Reset
REQ-017 rst SHALL force IDLE immediately, including mid-replay, with every output 0: x_out, y_out, step_count, step_valid, q_*, busy, done, reached and err.
REQ-018 After rst deasserts, the block SHALL take no action until start.

Configuration
REQ-016 Macro ROUTE_PLAYER_BOUNDS_CHECK_EN:
- Defined: a move below 0 or above 15 on either axis SHALL go to ERR.
- Undefined: coordinates SHALL wrap modulo 16 and err SHALL be tied 0.

Structure
REQ-019 Shared package rat_pkg SHALL hold:
- move encoding constants MOVE_UP, MOVE_RIGHT, MOVE_LEFT, MOVE_DOWN;
- the FSM state typedef;
- COORD_W=4, COORD_MAX=15, STEP_W=9.
REQ-020 Coordinate update SHALL be a combinational sub-module coord_stepper: x, y and move in; next x, next y and out_of_range out.

Verification
REQ-021 Reset: assert rst mid-EMIT -> same cycle, step_valid=0, busy=0, x/y=0.
REQ-022 Path 01,01,11 with step_ready tied 1, then q_finish -> steps (1,0),(2,0),(2,1); done=1, reached=0, step_count=3.
REQ-023 Path of 15x01 then 15x11 -> final (15,15); done=1, reached=1, step_count=30.
REQ-024 Backpressure: step_ready low for 5 cycles on step 2 -> x_out/y_out stable, step_valid high, no q_dequeue until acceptance.
REQ-025 First move 00 from (0,0):
- Macro defined -> err=1, step_count=0.
- Macro undefined -> step (0,15), err=0.
REQ-026 start pulsed while busy -> ignored; start in DONE -> q_load pulse and clean restart.

Source files
------------

// File: rtl/rat_pkg.sv
// rat_pkg: shared definitions for the route replay block.
//   - move encoding constants (MOVE_UP/RIGHT/LEFT/DOWN)
//   - replay FSM state type
//   - coordinate and step-counter widths
package rat_pkg;

  localparam int COORD_W   = 4;
  localparam int COORD_MAX = 15;
  localparam int STEP_W    = 9;

  // Typed limits so comparisons stay width-exact.
  localparam logic [COORD_W-1:0] COORD_TOP  = COORD_W'(COORD_MAX);
  localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] COORD_ONE  = COORD_W'(1);
  localparam logic [STEP_W-1:0]  STEP_MAX   = 9'd256;

  localparam logic [1:0] MOVE_UP    = 2'b00;  // y - 1
  localparam logic [1:0] MOVE_RIGHT = 2'b01;  // x + 1
  localparam logic [1:0] MOVE_LEFT  = 2'b10;  // x - 1
  localparam logic [1:0] MOVE_DOWN  = 2'b11;  // y + 1

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    APPLY = 3'd4,
    EMIT  = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

endpackage

// File: rtl/route_player_coord_stepper.sv
// coord_stepper: combinational single-move coordinate update.
// Ports:
//   x, y         in  current coordinate (COORD_W bits each)
//   move         in  2-bit move code
//   next_x/next_y out coordinate after the move, wrapping modulo 16
//   out_of_range out move would leave the 0..15 grid on either axis
module coord_stepper
  import rat_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         move,
  output logic [COORD_W-1:0] next_x,
  output logic [COORD_W-1:0] next_y,
  output logic               out_of_range
);

  // Apply one move; out_of_range flags the wrap case so the caller can choose.
  always_comb begin
    next_x       = x;
    next_y       = y;
    out_of_range = 1'b0;
    case (move)
      MOVE_UP: begin
        next_y       = y - COORD_ONE;
        out_of_range = (y == COORD_ZERO);
      end
      MOVE_RIGHT: begin
        next_x       = x + COORD_ONE;
        out_of_range = (x == COORD_TOP);
      end
      MOVE_LEFT: begin
        next_x       = x - COORD_ONE;
        out_of_range = (x == COORD_ZERO);
      end
      MOVE_DOWN: begin
        next_y       = y + COORD_ONE;
        out_of_range = (y == COORD_TOP);
      end
      default: begin
        next_x       = x;
        next_y       = y;
        out_of_range = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/route_player.sv
// route_player: replays a solved path from a move queue as a stream of
// (x, y) steps with valid/ready handshake.
// Configuration macro: ROUTE_PLAYER_BOUNDS_CHECK_EN
//   defined   - a move leaving the 0..15 grid stops replay with err
//   undefined - coordinates wrap modulo 16, err is tied 0
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               pulse, begin replay (ignored while busy)
//   q_move, q_finish    queue data (valid cycle after q_dequeue), queue empty
//   q_load, q_rst_front, q_dequeue   one-cycle queue control pulses
//   x_out, y_out        current replay coordinate
//   step_valid, step_ready  step handshake
//   step_count          accepted steps, 0..256
//   busy, done, reached, err  status
module route_player
  import rat_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         q_move,
  input  logic               q_finish,
  output logic               q_load,
  output logic               q_rst_front,
  output logic               q_dequeue,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               step_valid,
  input  logic               step_ready,
  output logic [STEP_W-1:0]  step_count,
  output logic               busy,
  output logic               done,
  output logic               reached,
  output logic               err
);

`ifdef ROUTE_PLAYER_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  state_t             state;
  state_t             next_state;
  logic [COORD_W-1:0] x_pos;
  logic [COORD_W-1:0] y_pos;
  logic [STEP_W-1:0]  count;
  logic [1:0]         move_reg;
  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;
  logic               oor;
  logic               apply_fail;

  coord_stepper u_stepper (
    .x            (x_pos),
    .y            (y_pos),
    .move         (move_reg),
    .next_x       (nx),
    .next_y       (ny),
    .out_of_range (oor)
  );

  // A 257th step is refused regardless of the bounds option.
  assign apply_fail = (BOUNDS_EN & oor) | (count == STEP_MAX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
        else       next_state = IDLE;
      end
      LOAD:  next_state = FETCH;
      FETCH: begin
        if (q_finish) next_state = DONE;
        else          next_state = WAIT;
      end
      WAIT:  next_state = APPLY;
      APPLY: begin
        if (apply_fail) next_state = ERR;
        else            next_state = EMIT;
      end
      EMIT: begin
        if (step_ready) next_state = FETCH;
        else            next_state = EMIT;
      end
      DONE: begin
        if (start) next_state = LOAD;
        else       next_state = DONE;
      end
      ERR: begin
        if (start) next_state = LOAD;
        else       next_state = ERR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: coordinate, step counter and captured move word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pos    <= COORD_ZERO;
      y_pos    <= COORD_ZERO;
      count    <= {STEP_W{1'b0}};
      move_reg <= 2'b00;
    end else begin
      case (state)
        LOAD: begin
          x_pos <= COORD_ZERO;
          y_pos <= COORD_ZERO;
          count <= {STEP_W{1'b0}};
        end
        WAIT: move_reg <= q_move;
        APPLY: begin
          if (!apply_fail) begin
            x_pos <= nx;
            y_pos <= ny;
          end else begin
            x_pos <= x_pos;
            y_pos <= y_pos;
          end
        end
        EMIT: begin
          if (step_ready && (count != STEP_MAX)) count <= count + 9'd1;
          else                                    count <= count;
        end
        default: begin
          x_pos <= x_pos;
          y_pos <= y_pos;
        end
      endcase
    end
  end

  // Output decode; all control outputs follow the (async-reset) state register.
  always_comb begin
    q_load      = 1'b0;
    q_rst_front = 1'b0;
    q_dequeue   = 1'b0;
    step_valid  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    reached     = 1'b0;
    err         = 1'b0;
    case (state)
      LOAD: begin
        q_load      = 1'b1;
        q_rst_front = 1'b1;
        busy        = 1'b1;
      end
      FETCH: begin
        q_dequeue = ~q_finish;
        busy      = 1'b1;
      end
      WAIT:  busy = 1'b1;
      APPLY: busy = 1'b1;
      EMIT: begin
        step_valid = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        reached = (x_pos == COORD_TOP) && (y_pos == COORD_TOP);
      end
      ERR:   err = BOUNDS_EN;
      default: busy = 1'b0;
    endcase
  end

  assign x_out      = x_pos;
  assign y_out      = y_pos;
  assign step_count = count;

endmodule

// File: tb/tb_route_player.sv
module tb_route_player;
  import rat_pkg::*;

`ifdef ROUTE_PLAYER_BOUNDS_CHECK_EN
  localparam int BOUNDS = 1;
`else
  localparam int BOUNDS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] q_move = 2'b00;
  logic       q_finish;
  logic       q_load, q_rst_front, q_dequeue;
  logic [3:0] x_out, y_out;
  logic       step_valid;
  logic       step_ready = 1'b1;
  logic [8:0] step_count;
  logic       busy, done, reached, err;

  int tests = 0;
  int fails = 0;

  route_player dut (
    .clk(clk), .rst(rst), .start(start), .q_move(q_move), .q_finish(q_finish),
    .q_load(q_load), .q_rst_front(q_rst_front), .q_dequeue(q_dequeue),
    .x_out(x_out), .y_out(y_out), .step_valid(step_valid), .step_ready(step_ready),
    .step_count(step_count), .busy(busy), .done(done), .reached(reached), .err(err)
  );

  always #5 clk = ~clk;

  // Path queue model.
  logic [1:0] path_mem [0:299];
  int plen = 0;
  int qidx = 0;
  int load_cnt = 0;
  int deq_cnt = 0;

  assign q_finish = (qidx >= plen);

  always @(posedge clk) begin
    if (q_load) load_cnt <= load_cnt + 1;
    if (q_rst_front) begin
      qidx <= 0;
    end else if (q_dequeue) begin
      q_move  <= (qidx < 300) ? path_mem[qidx] : 2'b00;
      qidx    <= qidx + 1;
      deq_cnt <= deq_cnt + 1;
    end
  end

  // Scoreboard.
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [8:0] cnt;
  } step_t;
  step_t exp_q[$];

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int x, input int y, input int cnt);
    step_t s;
    s.x = 4'(x);
    s.y = 4'(y);
    s.cnt = 9'(cnt);
    exp_q.push_back(s);
  endtask

  // Monitor: compare every accepted step against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && step_valid && step_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_step", 1, 0);
      end else begin
        step_t e;
        e = exp_q.pop_front();
        check("step_x", int'(x_out), int'(e.x));
        check("step_y", int'(y_out), int'(e.y));
        check("step_cnt", int'(step_count), int'(e.cnt));
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  initial begin
    int l0;
    int n;
    int d0;

    // Reset state
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_xy", int'({x_out, y_out}), 0);
    check("rst_cnt", int'(step_count), 0);
    check("rst_flags", int'({step_valid, done, reached, err, q_load, q_rst_front, q_dequeue}), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle_after_rst", int'({busy, q_load}), 0);

    // Short path 01,01,11
    path_mem[0] = 2'b01; path_mem[1] = 2'b01; path_mem[2] = 2'b11; plen = 3;
    push(1, 0, 0); push(2, 0, 1); push(2, 1, 2);
    pulse_start();
    wait_idle("t1_timeout");
    check("t1_done", int'(done), 1);
    check("t1_reached", int'(reached), 0);
    check("t1_err", int'(err), 0);
    check("t1_cnt", int'(step_count), 3);
    check("t1_sb_empty", exp_q.size(), 0);

    // Restart from DONE with full path to (15,15); stray start mid-run
    for (int i = 0; i < 15; i++) path_mem[i] = 2'b01;
    for (int i = 15; i < 30; i++) path_mem[i] = 2'b11;
    plen = 30;
    for (int k = 1; k <= 15; k++) push(k, 0, k - 1);
    for (int k = 1; k <= 15; k++) push(15, k, 14 + k);
    l0 = load_cnt;
    pulse_start();
    @(negedge clk);
    check("t2_q_load", int'(q_load), 1);
    check("t2_q_rst_front", int'(q_rst_front), 1);
    check("t2_done_clr", int'(done), 0);
    @(negedge clk);
    check("t2_q_load_1cyc", int'(q_load), 0);
    check("t2_busy", int'(busy), 1);
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("t2_timeout");
    check("t2_load_pulses", load_cnt - l0, 1);
    check("t2_done", int'(done), 1);
    check("t2_reached", int'(reached), 1);
    check("t2_cnt", int'(step_count), 30);
    check("t2_sb_empty", exp_q.size(), 0);

    // Backpressure on step 2
    path_mem[0] = 2'b01; path_mem[1] = 2'b01; path_mem[2] = 2'b01; path_mem[3] = 2'b11;
    plen = 4;
    push(1, 0, 0); push(2, 0, 1); push(3, 0, 2); push(3, 1, 3);
    step_ready = 1'b1;
    pulse_start();
    n = 0;
    while (step_count != 9'd1 && n < 100) begin @(posedge clk); #1; n++; end
    check("t3_first_accept", int'(step_count), 1);
    step_ready = 1'b0;
    n = 0;
    while (!step_valid && n < 100) begin @(posedge clk); #1; n++; end
    d0 = deq_cnt;
    for (int c = 0; c < 5; c++) begin
      check("t3_hold_x", int'(x_out), 2);
      check("t3_hold_y", int'(y_out), 0);
      check("t3_hold_valid", int'(step_valid), 1);
      check("t3_no_dequeue", deq_cnt - d0, 0);
      @(posedge clk); #1;
    end
    step_ready = 1'b1;
    wait_idle("t3_timeout");
    check("t3_done", int'(done), 1);
    check("t3_cnt", int'(step_count), 4);
    check("t3_sb_empty", exp_q.size(), 0);

    // First move 00 from origin
    path_mem[0] = 2'b00; plen = 1;
    if (BOUNDS == 0) push(0, 15, 0);
    pulse_start();
    wait_idle("t4_timeout");
    check("t4_err", int'(err), BOUNDS);
    check("t4_done", int'(done), 1 - BOUNDS);
    check("t4_cnt", int'(step_count), 1 - BOUNDS);
    check("t4_sb_empty", exp_q.size(), 0);

    // Saturation: 257 moves, the last is refused
    for (int i = 0; i < 257; i++) path_mem[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
    plen = 257;
    for (int k = 1; k <= 256; k++) push(k % 2, 0, k - 1);
    pulse_start();
    wait_idle("t5_timeout");
    check("t5_cnt", int'(step_count), 256);
    check("t5_done", int'(done), 0);
    check("t5_err", int'(err), BOUNDS);
    check("t5_x_frozen", int'(x_out), 0);
    check("t5_sb_empty", exp_q.size(), 0);

    // Reset mid-EMIT
    for (int i = 0; i < 5; i++) path_mem[i] = 2'b01;
    plen = 5;
    step_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!step_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("t6_in_emit", int'(step_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_valid", int'(step_valid), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_xy", int'({x_out, y_out}), 0);
    check("t6_cnt", int'(step_count), 0);
    check("t6_q", int'({q_load, q_rst_front, q_dequeue}), 0);
    @(posedge clk); #1 rst = 1'b0;
    step_ready = 1'b1;
    l0 = load_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("t6_idle_busy", int'(busy), 0);
    check("t6_no_load", load_cnt - l0, 0);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
